// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM states, response owner, funct3 access sizes.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  // funct3 access-size encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Wide enough for LATENCY-1 and STARVE_LIMIT up to 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, data and memory-port signals of the arbiter; slave = arbiter side, master = requesters/memory.
interface mem_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             fe_req;
  logic [WIDTH-1:0] fe_addr;
  logic             fe_flush;
  logic             fe_gnt;
  logic             fe_valid;
  logic [WIDTH-1:0] fe_rdata;

  logic             d_req;
  logic             d_we;
  logic [WIDTH-1:0] d_addr;
  logic [WIDTH-1:0] d_wdata;
  logic [2:0]       d_size;
  logic             d_gnt;
  logic             d_valid;
  logic [WIDTH-1:0] d_rdata;

  logic             m_en;
  logic             m_we;
  logic [WIDTH-1:0] m_addr;
  logic [WIDTH-1:0] m_wdata;
  logic [2:0]       m_size;
  logic [WIDTH-1:0] m_rdata;

  modport slave (
    input  fe_req, fe_addr, fe_flush,
    input  d_req, d_we, d_addr, d_wdata, d_size,
    input  m_rdata,
    output fe_gnt, fe_valid, fe_rdata,
    output d_gnt, d_valid, d_rdata,
    output m_en, m_we, m_addr, m_wdata, m_size
  );

  modport master (
    output fe_req, fe_addr, fe_flush,
    output d_req, d_we, d_addr, d_wdata, d_size,
    output m_rdata,
    input  fe_gnt, fe_valid, fe_rdata,
    input  d_gnt, d_valid, d_rdata,
    input  m_en, m_we, m_addr, m_wdata, m_size
  );
endinterface

// File: rtl/mem_arbiter_starve_counter.sv
// Counts consecutive data grants taken while fetch is waiting; saturates at LIMIT.
module mem_arbiter_starve_counter
  import mem_arbiter_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic fe_req,
  input  logic d_grant,
  input  logic f_grant,
  output logic at_limit
);

  logic [CNT_W-1:0] streak_q, streak_d;

  always_comb begin
    streak_d = streak_q;
    if (!fe_req || f_grant) begin
      streak_d = '0;
    end else if (d_grant && (streak_q != CNT_W'(LIMIT))) begin
      streak_d = streak_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

  assign at_limit = (streak_q == CNT_W'(LIMIT));

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) single-port memory arbiter, one access in flight,
// combinational grant in IDLE and response LATENCY+1 cycles after the grant.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int LATENCY      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  arb_state_e       state_q, state_d;
  owner_e           owner_q, owner_d;
  logic             we_q, we_d;
  logic             flush_q, flush_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] fe_rdata_q, fe_rdata_d;
  logic [WIDTH-1:0] d_rdata_q, d_rdata_d;

  logic can_grant;
  logic d_win;
  logic fe_win;
  logic at_limit;

  // Gating on reset keeps grants (and the memory port) quiet while reset is held.
  always_comb begin
    can_grant = (state_q == IDLE) && reset;
    d_win     = can_grant && bus.d_req && !(bus.fe_req && at_limit);
    fe_win    = can_grant && bus.fe_req && !d_win;
  end

  mem_arbiter_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .reset    (reset),
    .fe_req   (bus.fe_req),
    .d_grant  (d_win),
    .f_grant  (fe_win),
    .at_limit (at_limit)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    flush_d    = flush_q;
    cnt_d      = cnt_q;
    fe_rdata_d = fe_rdata_q;
    d_rdata_d  = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (d_win || fe_win) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(LATENCY - 1);
          owner_d = d_win ? OWN_DATA : OWN_FETCH;
          we_d    = d_win && bus.d_we;
          flush_d = 1'b0;
        end
      end
      WAIT: begin
        if ((owner_q == OWN_FETCH) && bus.fe_flush) begin
          flush_d = 1'b1;
        end
        if (cnt_q == '0) begin
          state_d = RESP;
          if (owner_q == OWN_DATA) begin
            d_rdata_d = we_q ? '0 : bus.m_rdata;
          end else if (!(flush_q || bus.fe_flush)) begin
            fe_rdata_d = bus.m_rdata;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if ((owner_q == OWN_FETCH) && bus.fe_flush) begin
          flush_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      owner_q    <= OWN_FETCH;
      we_q       <= 1'b0;
      flush_q    <= 1'b0;
      cnt_q      <= '0;
      fe_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      flush_q    <= flush_d;
      cnt_q      <= cnt_d;
      fe_rdata_q <= fe_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // Memory port is live only in the grant cycle; fetches are always word reads.
  always_comb begin
    bus.m_en    = d_win || fe_win;
    bus.m_we    = d_win && bus.d_we;
    bus.m_addr  = d_win ? bus.d_addr : (fe_win ? bus.fe_addr : '0);
    bus.m_wdata = d_win ? bus.d_wdata : '0;
    bus.m_size  = d_win ? bus.d_size : (fe_win ? F3_W : 3'b000);
  end

  assign bus.d_gnt    = d_win;
  assign bus.fe_gnt   = fe_win;
  assign bus.d_valid  = (state_q == RESP) && (owner_q == OWN_DATA);
  assign bus.fe_valid = (state_q == RESP) && (owner_q == OWN_FETCH) && !flush_q && !bus.fe_flush;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.fe_rdata = fe_rdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: address and data width.
REQ-002 Parameter LATENCY, default 1: memory read latency in cycles, from m_en to m_rdata valid; legal range 1..15.
REQ-003 Parameter STARVE_LIMIT, default 4: consecutive data grants allowed while fetch waits; legal range 1..15.
REQ-004 Ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- fe_req  in  1  fetch request.
- fe_addr  in  WIDTH  fetch address.
- fe_flush  in  1  discard any outstanding fetch response.
- fe_gnt  out  1  fetch request accepted.
- fe_valid  out  1  fetch response valid.
- fe_rdata  out  WIDTH  fetch response data.
- d_req  in  1  load/store request.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  WIDTH  data address.
- d_wdata  in  WIDTH  store data.
- d_size  in  3  access size, funct3 encoding.
- d_gnt  out  1  data request accepted.
- d_valid  out  1  data response valid (load data or store ack).
- d_rdata  out  WIDTH  load data; 0 for stores.
- m_en, m_we  out  1  memory port enable and write enable.
- m_addr, m_wdata  out  WIDTH  memory address and write data.
- m_size  out  3  memory access size.
- m_rdata  in  WIDTH  memory read data.

Function
REQ-005 FSM states: IDLE, WAIT, RESP; one transaction in flight at most.
REQ-006 In IDLE with any request pending, the arbiter SHALL grant in the same cycle (combinational gnt), drive m_en=1 with the winner's address/controls, load cnt=LATENCY-1, go to WAIT.
REQ-007 Priority: data over fetch, except when fe_req=1, d_req=1 and streak==STARVE_LIMIT, in which case fetch wins.
REQ-008 streak SHALL increment on a data grant with fe_req=1, clear on any fetch grant or any cycle with fe_req=0, and saturate at STARVE_LIMIT.
REQ-009 WAIT SHALL decrement cnt; at cnt==0 it SHALL capture m_rdata (loads/fetches) or 0 (stores) and go to RESP.
REQ-010 RESP SHALL pulse the owner's valid for exactly one cycle with registered rdata, then return to IDLE; no grant in WAIT or RESP.
REQ-011 Access latency from gnt to valid SHALL be LATENCY+1 cycles; throughput is one access per LATENCY+2 cycles.
REQ-012 Requesters SHALL hold req/addr/data stable until gnt; gnt is never asserted without req.
REQ-013 m_en, m_we, and the gnt outputs SHALL be 0 outside the IDLE grant cycle; m_we=d_we only on data grants.
REQ-014 fe_flush=1 while a fetch is in WAIT or RESP SHALL suppress that fe_valid; the FSM still completes the sequence. fe_flush in IDLE has no effect and does not block the next grant.
REQ-015 fe_rdata/d_rdata SHALL hold their last value between valid pulses.

Reset
REQ-016 reset=0 SHALL asynchronously force IDLE, cnt=0, streak=0, all outputs 0, including mid-transaction; no valid is issued for the aborted access.
REQ-017 After reset release, the first grant occurs no earlier than the first rising edge with reset=1.

Structure
REQ-018 State encoding and the funct3 size constants SHALL reside in the shared processor package.
REQ-019 Single module; the starvation counter MAY be a sub-module, starve_counter.

Verification
REQ-020 Lone load d_addr=0x10, LATENCY=1, m_rdata=0xDEADBEEF -> d_gnt at cycle 0, d_valid with 0xDEADBEEF at cycle 2.
REQ-021 fe_req and d_req held high continuously, STARVE_LIMIT=4 -> grant pattern D,D,D,D,F repeating.
REQ-022 Store d_addr=0x40000000, d_wdata=0x5 -> m_we=1 for one cycle, d_valid with d_rdata=0 two cycles later.
REQ-023 Fetch granted, fe_flush=1 in WAIT -> no fe_valid; a new fetch is granted in the cycle after RESP.
REQ-024 reset asserted in WAIT -> outputs 0 immediately; after release, a pending d_req is granted on the first edge.
REQ-025 LATENCY=3, single fetch -> fe_valid 4 cycles after fe_gnt; m_en high for exactly one cycle.
